// File: rtl/sdram_arb_pkg.sv
// Shared command codes and FSM state encoding for the SDRAM ring-buffer arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        CMD_REF = 2'b00,
        CMD_WR  = 2'b01,
        CMD_RD  = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

endpackage

// File: rtl/sdram_arb_ring_ptr.sv
// Burst-granular ring pointer: steps BURST_LEN words and wraps to BASE_ADDR.
module sdram_arb_ring_ptr #(
    parameter int ADDR_W      = 24,
    parameter int BASE_ADDR   = 0,
    parameter int RING_BURSTS = 1024,
    parameter int BURST_LEN   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_ptr
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] LAST =
        ADDR_W'(BASE_ADDR + (RING_BURSTS - 1) * BURST_LEN);

    logic [ADDR_W-1:0] r_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= BASE;
        end else if (i_adv) begin
            r_ptr <= (r_ptr == LAST) ? BASE : r_ptr + STEP;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sdram_fifo_arbiter.sv
// Refresh / burst-write / burst-read scheduler using SDRAM as a ring buffer.
// Optional command watchdog enabled by defining SDRAM_ARB_WDOG_EN.
module sdram_fifo_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int USE_W       = 10,
    parameter int FIFO_DEPTH  = 512,
    parameter int BURST_LEN   = 8,
    parameter int BASE_ADDR   = 0,
    parameter int RING_BURSTS = 1024,
    parameter int LVL_W       = 11,
    parameter int WDOG_CYCLES = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [USE_W-1:0]  i_wr_fifo_use,
    input  logic [USE_W-1:0]  i_rd_fifo_use,
    input  logic              i_rd_active,
    input  logic              i_ref_req,
    output logic              o_ref_ack,
    output logic              o_cmd_valid,
    output logic [1:0]        o_cmd_type,
    output logic [ADDR_W-1:0] o_cmd_addr,
    input  logic              i_cmd_ready,
    input  logic              i_cmd_done,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [LVL_W:0] RING_MAX = (LVL_W+1)'(RING_BURSTS);
    localparam logic [USE_W:0] BURST_U  = (USE_W+1)'(BURST_LEN);
    localparam logic [USE_W:0] DEPTH_U  = (USE_W+1)'(FIFO_DEPTH);

    state_t            r_state;
    cmd_t              r_type;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic              r_ack;
    logic              r_rr;
    logic [LVL_W-1:0]  r_level;

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_done;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;

    assign w_wr_ok = ({1'b0, i_wr_fifo_use} >= BURST_U) &&
                     ({1'b0, r_level} < RING_MAX);
    // Free-space test written as an add so an oversized count cannot wrap.
    assign w_rd_ok = i_rd_active && (r_level != '0) &&
                     ({1'b0, i_rd_fifo_use} + BURST_U <= DEPTH_U);
    assign w_done  = (r_state == ST_WAIT) && i_cmd_done;

`ifdef SDRAM_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (r_state == ST_WAIT) ? r_wdog + 1'b1 : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !i_cmd_done &&
                       (r_wdog == WDOG_LAST);
    assign o_err     = r_err;
`else
    logic w_unused_wdog;

    assign w_unused_wdog = (WDOG_CYCLES == 0);
    assign w_timeout     = 1'b0;
    assign o_err         = 1'b0;
`endif

    sdram_arb_ring_ptr #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .RING_BURSTS (RING_BURSTS),
        .BURST_LEN   (BURST_LEN)
    ) u_wr_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_adv (w_done && (r_type == CMD_WR)),
        .o_ptr (w_wr_ptr)
    );

    sdram_arb_ring_ptr #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .RING_BURSTS (RING_BURSTS),
        .BURST_LEN   (BURST_LEN)
    ) u_rd_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_adv (w_done && (r_type == CMD_RD)),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_type  <= CMD_REF;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_rr    <= 1'b0;
            r_level <= '0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_ref_req) begin
                        r_type  <= CMD_REF;
                        r_addr  <= '0;
                        r_valid <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else if (w_wr_ok && (!w_rd_ok || !r_rr)) begin
                        r_type  <= CMD_WR;
                        r_addr  <= w_wr_ptr;
                        r_valid <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else if (w_rd_ok) begin
                        r_type  <= CMD_RD;
                        r_addr  <= w_rd_ptr;
                        r_valid <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_cmd_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_cmd_done) begin
                        r_state <= ST_IDLE;
                        unique case (r_type)
                            CMD_REF: r_ack <= 1'b1;
                            CMD_WR: begin
                                r_level <= r_level + LVL_W'(1);
                                r_rr    <= 1'b1;
                            end
                            CMD_RD: begin
                                r_level <= r_level - LVL_W'(1);
                                r_rr    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end else if (w_timeout) begin
                        // Pointers and level untouched so the burst is retried.
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ref_ack   = r_ack;
    assign o_cmd_valid = r_valid;
    assign o_cmd_type  = r_type;
    assign o_cmd_addr  = r_addr;
    assign o_level     = r_level;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdram_fifo_arbiter.sv
// Randomised bench for sdram_fifo_arbiter.
// Queue-based ring model; optional watchdog.
module tb_sdram_fifo_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W = 24;
  localparam int USE_W  = 10;
  localparam int FD     = 512;
  localparam int BL     = 8;
  localparam int RB     = 8;
  localparam int LVL_W  = 11;
  localparam int WDOG   = 15;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [USE_W-1:0]  i_wr_fifo_use = '0;
  logic [USE_W-1:0]  i_rd_fifo_use = '0;
  logic              i_rd_active = 1'b0;
  logic              i_ref_req = 1'b0;
  logic              o_ref_ack;
  logic              o_cmd_valid;
  logic [1:0]        o_cmd_type;
  logic [ADDR_W-1:0] o_cmd_addr;
  logic              i_cmd_ready = 1'b0;
  logic              i_cmd_done = 1'b0;
  logic [LVL_W-1:0]  o_level;
  logic              o_busy;
  logic              o_err;

  always #5 clk = ~clk;

  sdram_fifo_arbiter #(
    .ADDR_W      (ADDR_W),
    .USE_W       (USE_W),
    .FIFO_DEPTH  (FD),
    .BURST_LEN   (BL),
    .BASE_ADDR   (0),
    .RING_BURSTS (RB),
    .LVL_W       (LVL_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_wr_fifo_use (i_wr_fifo_use),
    .i_rd_fifo_use (i_rd_fifo_use),
    .i_rd_active   (i_rd_active),
    .i_ref_req     (i_ref_req),
    .o_ref_ack     (o_ref_ack),
    .o_cmd_valid   (o_cmd_valid),
    .o_cmd_type    (o_cmd_type),
    .o_cmd_addr    (o_cmd_addr),
    .i_cmd_ready   (i_cmd_ready),
    .i_cmd_done    (i_cmd_done),
    .o_level       (o_level),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  int n_chk = 0;
  int n_err = 0;

  int                m_level;
  int                m_wp;
  logic [ADDR_W-1:0] m_q[$];
  bit                m_rr;
  bit                m_err;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: obs %0d exp %0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_wp    = 0;
    m_q.delete();
    m_rr    = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic predict(
    output bit any,
    output logic [1:0] et,
    output logic [ADDR_W-1:0] ea
  );
    bit wok, rok;
    wok = (int'(i_wr_fifo_use) >= BL) &&
          (m_level < RB);
    rok = i_rd_active && (m_level > 0) &&
          ((FD - int'(i_rd_fifo_use)) >= BL);
    any = 1'b1;
    et  = CMD_REF;
    ea  = '0;
    if (i_ref_req) begin
      et = CMD_REF;
    end else if (wok && (!rok || !m_rr)) begin
      et = CMD_WR;
      ea = ADDR_W'(m_wp);
    end else if (rok) begin
      et = CMD_RD;
      ea = m_q[0];
    end else begin
      any = 1'b0;
    end
  endtask

  task automatic check_reset();
    chk("rst_valid", o_cmd_valid, 1'b0);
    chk("rst_type", o_cmd_type, 2'b00);
    chk("rst_addr", o_cmd_addr, '0);
    chk("rst_ack", o_ref_ack, 1'b0);
    chk("rst_level", o_level, '0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_err", o_err, 1'b0);
  endtask

  task automatic run_cmd(input int rdy_dly,
                         input int done_dly);
    bit                any;
    logic [1:0]        et;
    logic [ADDR_W-1:0] ea;
    predict(any, et, ea);
    @(negedge clk);
    chk("ack_low", o_ref_ack, 1'b0);
    chk("grant", o_cmd_valid, any);
    if (!any) begin
      chk("idle_busy", o_busy, 1'b0);
      return;
    end
    chk("type", o_cmd_type, et);
    chk("addr", o_cmd_addr, ea);
    chk("busy", o_busy, 1'b1);
    for (int k = 0; k < rdy_dly; k++) begin
      i_cmd_done = (k == 1);
      @(negedge clk);
      chk("hold_valid", o_cmd_valid, 1'b1);
      chk("hold_type", o_cmd_type, et);
      chk("hold_addr", o_cmd_addr, ea);
    end
    i_cmd_done  = 1'b0;
    i_cmd_ready = 1'b1;
    @(negedge clk);
    i_cmd_ready = 1'b0;
    chk("valid_drop", o_cmd_valid, 1'b0);
    repeat (done_dly) @(negedge clk);
    i_cmd_done = 1'b1;
    @(negedge clk);
    i_cmd_done = 1'b0;
    if (et == CMD_WR) begin
      m_q.push_back(ea);
      m_wp = (m_wp + BL) % (RB * BL);
      m_level++;
      m_rr = 1'b1;
    end else if (et == CMD_RD) begin
      void'(m_q.pop_front());
      m_level--;
      m_rr = 1'b0;
    end
    chk("ref_ack", o_ref_ack, (et == CMD_REF));
    chk("level", o_level, LVL_W'(m_level));
    chk("done_busy", o_busy, 1'b0);
    chk("err", o_err, m_err);
  endtask

  task automatic set_in(input int wuse,
                        input int ruse,
                        input bit act,
                        input bit rref);
    i_wr_fifo_use = USE_W'(wuse);
    i_rd_fifo_use = USE_W'(ruse);
    i_rd_active   = act;
    i_ref_req     = rref;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    i_rst = 1'b0;

    set_in(8, 0, 0, 0);
    run_cmd(0, 2);
    run_cmd(1, 0);

    set_in(8, 0, 0, 1);
    run_cmd(0, 1);
    set_in(8, 0, 0, 0);
    run_cmd(0, 0);
    run_cmd(2, 3);

    set_in(100, 0, 1, 0);
    for (int i = 0; i < 4; i++) run_cmd(0, 1);

    set_in(64, 0, 0, 0);
    for (int i = 0; i < 10 && m_level < RB; i++)
      run_cmd(0, 0);
    chk("level_full", o_level, LVL_W'(RB));
    run_cmd(0, 0);
    set_in(0, 0, 1, 0);
    for (int i = 0; i < 10 && m_level > 0; i++)
      run_cmd(1, 1);
    run_cmd(0, 0);
    set_in(8, 600, 1, 0);
    run_cmd(0, 0);
    set_in(8, 0, 0, 0);
    run_cmd(10, 2);

    for (int i = 0; i < 40; i++) begin
      set_in(($urandom_range(0, 3) == 0) ?
               $urandom_range(0, 1023) :
               $urandom_range(0, 16),
             ($urandom_range(0, 3) == 0) ?
               $urandom_range(505, 1023) :
               $urandom_range(0, 510),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0);
      run_cmd($urandom_range(0, 3),
              $urandom_range(0, 4));
    end

`ifdef SDRAM_ARB_WDOG_EN
    set_in(8, 0, 0, 0);
    if (m_level >= RB) set_in(0, 0, 1, 0);
    @(negedge clk);
    chk("wd_grant", o_cmd_valid, 1'b1);
    i_cmd_ready = 1'b1;
    @(negedge clk);
    i_cmd_ready = 1'b0;
    repeat (14) @(negedge clk);
    chk("wd_wait", o_busy, 1'b1);
    @(negedge clk);
    chk("wd_idle", o_busy, 1'b0);
    chk("wd_err", o_err, 1'b1);
    chk("wd_level", o_level, LVL_W'(m_level));
    m_err = 1'b1;
    run_cmd(0, 1);
`endif

    set_in(8, 0, 0, 0);
    if (m_level >= RB) set_in(0, 0, 1, 0);
    @(negedge clk);
    chk("mid_grant", o_cmd_valid, 1'b1);
    i_cmd_ready = 1'b1;
    @(negedge clk);
    i_cmd_ready = 1'b0;
    @(negedge clk);
    chk("mid_busy", o_busy, 1'b1);
    i_rst = 1'b1;
    #1;
    check_reset();
    model_reset();
    set_in(8, 0, 0, 0);
    @(negedge clk);
    i_rst = 1'b0;
    run_cmd(0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
